// File: rtl/ladybird_fifo_arbiter.sv
// Packet-locking round-robin arbiter feeding a FIFO write port.
// A requester keeps the grant from its first beat until its last beat transfers.
module ladybird_fifo_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int SRC_W  = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    anrst,
   input  logic                    nrst,
   input  logic [N_REQ*DATA_W-1:0] in_data,
   input  logic [N_REQ-1:0]        in_valid,
   input  logic [N_REQ-1:0]        in_last,
   output logic [N_REQ-1:0]        in_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic                    out_valid,
   output logic                    out_last,
   output logic [SRC_W-1:0]        out_src,
   input  logic                    out_ready,
   output logic                    grant_active,
   output logic                    o_dbg_state,
   output logic [SRC_W-1:0]        o_dbg_gnt,
   output logic [SRC_W-1:0]        o_dbg_rr_ptr
);

   // Handshake: a beat moves on a rising edge where valid and ready are both high;
   // ready never waits on valid, and valid/payload hold while ready is low.
   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [SRC_W-1:0]  r_gnt, w_gnt_nxt;
   logic [SRC_W-1:0]  r_rr_ptr, w_rr_nxt;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid;
   logic              r_out_last;
   logic [SRC_W-1:0]  r_out_src;

   logic [DATA_W-1:0] w_in_data [N_REQ];
   logic              w_pick_found;
   logic [SRC_W-1:0]  w_pick;
   logic [SRC_W:0]    w_sum;
   logic              w_out_free;
   logic              w_xfer;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_lane
         assign w_in_data[gi] = in_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Rotating priority scan starting at r_rr_ptr, wrapping modulo N_REQ.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick       = '0;
      w_sum        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
         if (w_sum >= (SRC_W+1)'(N_REQ))
            w_sum = w_sum - (SRC_W+1)'(N_REQ);
         if (!w_pick_found && in_valid[w_sum[SRC_W-1:0]]) begin
            w_pick_found = 1'b1;
            w_pick       = w_sum[SRC_W-1:0];
         end
      end
   end

   assign w_out_free = ~r_out_valid | out_ready;
   assign w_xfer     = (r_state == S_LOCKED) & w_out_free & in_valid[r_gnt];

   always_comb begin
      in_ready = '0;
      if (r_state == S_LOCKED && w_out_free)
         in_ready[r_gnt] = 1'b1;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_rr_nxt    = r_rr_ptr;
      case (r_state)
         S_IDLE: begin
            if (w_pick_found) begin
               w_state_nxt = S_LOCKED;
               w_gnt_nxt   = w_pick;
            end
         end
         S_LOCKED: begin
            if (w_xfer && in_last[r_gnt]) begin
               w_state_nxt = S_IDLE;
               w_rr_nxt    = (r_gnt == SRC_W'(N_REQ-1)) ? '0 : r_gnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         r_state     <= S_IDLE;
         r_gnt       <= '0;
         r_rr_ptr    <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_src   <= '0;
      end else if (!nrst) begin
         r_state     <= S_IDLE;
         r_gnt       <= '0;
         r_rr_ptr    <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_src   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_rr_ptr <= w_rr_nxt;
         if (w_xfer) begin
            r_out_data  <= w_in_data[r_gnt];
            r_out_last  <= in_last[r_gnt];
            r_out_src   <= r_gnt;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data     = r_out_data;
   assign out_valid    = r_out_valid;
   assign out_last     = r_out_last;
   assign out_src      = r_out_src;
   assign grant_active = (r_state == S_LOCKED);
   assign o_dbg_state  = r_state;
   assign o_dbg_gnt    = r_gnt;
   assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_ladybird_fifo_arbiter.sv
// Bench for ladybird_fifo_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level round-robin model with an output queue.
module tb_ladybird_fifo_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int SW = 2;
   localparam int QW = SW + 1 + DW;

   logic          clk = 1'b0;
   logic          anrst = 1'b0;
   logic          nrst = 1'b1;
   logic [N*DW-1:0] in_data = '0;
   logic [N-1:0]  in_valid = '0;
   logic [N-1:0]  in_last = '0;
   logic [N-1:0]  in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_last;
   logic [SW-1:0] out_src;
   logic          out_ready = 1'b1;
   logic          grant_active;
   logic          dbg_state;
   logic [SW-1:0] dbg_gnt;
   logic [SW-1:0] dbg_rr;

   int n_cmp = 0;
   int n_err = 0;
   logic [QW-1:0] exp_q[$];

   ladybird_fifo_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
      .clk(clk), .anrst(anrst), .nrst(nrst),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_src(out_src),
      .out_ready(out_ready), .grant_active(grant_active),
      .o_dbg_state(dbg_state), .o_dbg_gnt(dbg_gnt), .o_dbg_rr_ptr(dbg_rr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_lane(input int i, input logic v, input logic [DW-1:0] d, input logic l);
      in_valid[i]         = v;
      in_data[i*DW +: DW] = d;
      in_last[i]          = l;
   endtask

   task automatic clear_inputs();
      in_valid  = '0;
      in_last   = '0;
      in_data   = '0;
      out_ready = 1'b1;
   endtask

   task automatic apply_reset();
      clear_inputs();
      nrst  = 1'b1;
      anrst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      anrst = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      in_valid = 4'b1111;
      anrst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if ({out_data, out_last, out_src} !== '0) begin n_err++; $display("FAIL reset_out_payload: got %h/%b/%0d want 0", out_data, out_last, out_src); end
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      n_cmp++; if (grant_active !== 1'b0 || dbg_rr !== 2'd0 || dbg_gnt !== 2'd0) begin n_err++; $display("FAIL reset_state: ga=%b rr=%0d gnt=%0d want 0/0/0", grant_active, dbg_rr, dbg_gnt); end
      apply_reset();
   endtask

   task automatic test_three_beat();
      apply_reset();
      set_lane(2, 1'b1, 8'h11, 1'b0);
      settle();
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL idle_in_ready: got %b want 0000", in_ready); end
      step();
      n_cmp++; if (grant_active !== 1'b1 || dbg_gnt !== 2'd2 || out_valid !== 1'b0) begin n_err++; $display("FAIL tb_lock: ga=%b gnt=%0d ov=%b want 1/2/0", grant_active, dbg_gnt, out_valid); end
      settle();
      n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL tb_in_ready: got %b want 0100", in_ready); end
      step();
      n_cmp++; if ({out_valid, out_data, out_last, out_src} !== {1'b1, 8'h11, 1'b0, 2'd2}) begin n_err++; $display("FAIL tb_beat0: got v=%b d=%h l=%b s=%0d want 1/11/0/2", out_valid, out_data, out_last, out_src); end
      set_lane(2, 1'b1, 8'h22, 1'b0);
      step();
      n_cmp++; if ({out_valid, out_data, out_last, out_src} !== {1'b1, 8'h22, 1'b0, 2'd2}) begin n_err++; $display("FAIL tb_beat1: got v=%b d=%h l=%b s=%0d want 1/22/0/2", out_valid, out_data, out_last, out_src); end
      set_lane(2, 1'b1, 8'h33, 1'b1);
      step();
      n_cmp++; if ({out_valid, out_data, out_last, out_src} !== {1'b1, 8'h33, 1'b1, 2'd2}) begin n_err++; $display("FAIL tb_beat2: got v=%b d=%h l=%b s=%0d want 1/33/1/2", out_valid, out_data, out_last, out_src); end
      n_cmp++; if (grant_active !== 1'b0 || dbg_rr !== 2'd3) begin n_err++; $display("FAIL tb_release: ga=%b rr=%0d want 0/3", grant_active, dbg_rr); end
      set_lane(2, 1'b0, 8'h00, 1'b0);
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL tb_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_round_robin();
      int exp_s;
      apply_reset();
      for (int i = 0; i < N; i++) set_lane(i, 1'b1, 8'hB0 + 8'(i), 1'b1);
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k % 2 == 0) begin
            exp_s = (k / 2 - 1) % N;
            n_cmp++; if ({out_valid, out_src, out_data, grant_active} !== {1'b1, 2'(exp_s), 8'hB0 + 8'(exp_s), 1'b0}) begin
               n_err++; $display("FAIL rr_beat%0d: got v=%b s=%0d d=%h ga=%b want 1/%0d/%h/0", k, out_valid, out_src, out_data, grant_active, exp_s, 8'hB0 + 8'(exp_s)); end
         end else begin
            exp_s = ((k - 1) / 2) % N;
            n_cmp++; if ({out_valid, grant_active, dbg_gnt} !== {1'b0, 1'b1, 2'(exp_s)}) begin
               n_err++; $display("FAIL rr_grant%0d: got v=%b ga=%b gnt=%0d want 0/1/%0d", k, out_valid, grant_active, dbg_gnt, exp_s); end
         end
      end
   endtask

   task automatic test_stall_hold();
      apply_reset();
      set_lane(0, 1'b1, 8'h01, 1'b1);
      step(); step();
      set_lane(0, 1'b1, 8'h02, 1'b1);
      set_lane(1, 1'b1, 8'hA0, 1'b0);
      step();
      n_cmp++; if (dbg_gnt !== 2'd1 || grant_active !== 1'b1) begin n_err++; $display("FAIL sh_grant: gnt=%0d ga=%b want 1/1", dbg_gnt, grant_active); end
      step();
      n_cmp++; if ({out_valid, out_data, out_src} !== {1'b1, 8'hA0, 2'd1}) begin n_err++; $display("FAIL sh_a0: got v=%b d=%h s=%0d want 1/a0/1", out_valid, out_data, out_src); end
      set_lane(1, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         n_cmp++; if ({grant_active, dbg_gnt, out_valid} !== {1'b1, 2'd1, 1'b0}) begin n_err++; $display("FAIL sh_hold%0d: ga=%b gnt=%0d ov=%b want 1/1/0", k, grant_active, dbg_gnt, out_valid); end
      end
      set_lane(1, 1'b1, 8'hA1, 1'b1);
      step();
      n_cmp++; if ({out_valid, out_data, out_last, out_src} !== {1'b1, 8'hA1, 1'b1, 2'd1}) begin n_err++; $display("FAIL sh_a1: got v=%b d=%h l=%b s=%0d want 1/a1/1/1", out_valid, out_data, out_last, out_src); end
      set_lane(1, 1'b0, 8'h00, 1'b0);
      step();
      n_cmp++; if (dbg_gnt !== 2'd0 || grant_active !== 1'b1) begin n_err++; $display("FAIL sh_next: gnt=%0d ga=%b want 0/1", dbg_gnt, grant_active); end
      step();
      n_cmp++; if ({out_valid, out_data, out_src} !== {1'b1, 8'h02, 2'd0}) begin n_err++; $display("FAIL sh_req0: got v=%b d=%h s=%0d want 1/02/0", out_valid, out_data, out_src); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      set_lane(2, 1'b1, 8'h5C, 1'b0);
      step(); step();
      out_ready = 1'b0;
      set_lane(2, 1'b1, 8'h5D, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step();
         n_cmp++; if ({out_valid, out_data, out_src} !== {1'b1, 8'h5C, 2'd2}) begin n_err++; $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d want 1/5c/2", k, out_valid, out_data, out_src); end
         settle();
         n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready%0d: got %b want 0000", k, in_ready); end
      end
      out_ready = 1'b1;
      settle();
      n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release: got %b want 0100", in_ready); end
      step();
      n_cmp++; if ({out_valid, out_data, out_last} !== {1'b1, 8'h5D, 1'b1}) begin n_err++; $display("FAIL bp_5d: got v=%b d=%h l=%b want 1/5d/1", out_valid, out_data, out_last); end
      set_lane(2, 1'b0, 8'h00, 1'b0);
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_wrap();
      apply_reset();
      set_lane(3, 1'b1, 8'hD3, 1'b1);
      step(); step();
      n_cmp++; if ({out_src, dbg_rr, grant_active} !== {2'd3, 2'd0, 1'b0}) begin n_err++; $display("FAIL wr_ptr: src=%0d rr=%0d ga=%b want 3/0/0", out_src, dbg_rr, grant_active); end
      set_lane(0, 1'b1, 8'hD0, 1'b1);
      set_lane(3, 1'b1, 8'hD4, 1'b1);
      step();
      n_cmp++; if (dbg_gnt !== 2'd0) begin n_err++; $display("FAIL wr_grant: got %0d want 0", dbg_gnt); end
      step();
      n_cmp++; if ({out_data, out_src} !== {8'hD0, 2'd0}) begin n_err++; $display("FAIL wr_beat: got d=%h s=%0d want d0/0", out_data, out_src); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      set_lane(1, 1'b1, 8'hE0, 1'b0);
      step(); step();
      nrst = 1'b0;
      set_lane(1, 1'b1, 8'hE1, 1'b0);
      step();
      n_cmp++; if ({out_valid, out_data, grant_active, dbg_rr} !== {1'b0, 8'h00, 1'b0, 2'd0}) begin n_err++; $display("FAIL sr_clear: v=%b d=%h ga=%b rr=%0d want 0/00/0/0", out_valid, out_data, grant_active, dbg_rr); end
      nrst = 1'b1;
      set_lane(1, 1'b1, 8'hE2, 1'b1);
      set_lane(2, 1'b1, 8'hE3, 1'b1);
      step();
      n_cmp++; if (dbg_gnt !== 2'd1 || grant_active !== 1'b1) begin n_err++; $display("FAIL sr_regrant: gnt=%0d ga=%b want 1/1", dbg_gnt, grant_active); end
      apply_reset();
      set_lane(3, 1'b1, 8'hF0, 1'b0);
      step(); step();
      #2 anrst = 1'b0;
      #1;
      n_cmp++; if ({out_valid, out_data, grant_active, in_ready, dbg_rr} !== {1'b0, 8'h00, 1'b0, 4'b0000, 2'd0}) begin
         n_err++; $display("FAIL ar_clear: v=%b d=%h ga=%b rdy=%b rr=%0d want 0/00/0/0000/0", out_valid, out_data, grant_active, in_ready, dbg_rr); end
      step();
      anrst = 1'b1;
      set_lane(2, 1'b1, 8'hF2, 1'b1);
      step();
      n_cmp++; if (dbg_gnt !== 2'd2 || grant_active !== 1'b1) begin n_err++; $display("FAIL ar_regrant: gnt=%0d ga=%b want 2/1", dbg_gnt, grant_active); end
      step();
      n_cmp++; if ({out_valid, out_data, out_src} !== {1'b1, 8'hF2, 2'd2}) begin n_err++; $display("FAIL ar_beat: got v=%b d=%h s=%0d want 1/f2/2", out_valid, out_data, out_src); end
   endtask

   // Model: who owns the grant, where the rotation resumes, whether the output slot is full.
   task automatic test_random();
      bit m_locked = 0;
      int m_gnt = 0;
      int m_rr = 0;
      bit m_ov = 0;
      logic [N-1:0] exp_ready;
      logic [QW-1:0] front;
      bit xfer;
      int cand;
      apply_reset();
      exp_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++)
            set_lane(i, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
         out_ready = $urandom_range(0, 3) != 0;
         settle();
         exp_ready = '0;
         if (m_locked && (!m_ov || out_ready)) exp_ready[m_gnt] = 1'b1;
         n_cmp++; if (in_ready !== exp_ready || grant_active !== m_locked || out_valid !== m_ov) begin
            n_err++; $display("FAIL rnd_ctrl@%0d: rdy=%b ga=%b ov=%b want %b/%b/%b", cyc, in_ready, grant_active, out_valid, exp_ready, m_locked, m_ov); end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL rnd_extra@%0d: got beat s=%0d d=%h want none", cyc, out_src, out_data);
            end else begin
               front = exp_q.pop_front();
               if ({out_src, out_last, out_data} !== front) begin
                  n_err++; $display("FAIL rnd_beat@%0d: got s=%0d l=%b d=%h want %h", cyc, out_src, out_last, out_data, front); end
            end
         end
         xfer = m_locked && (!m_ov || out_ready) && in_valid[m_gnt];
         if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
               cand = (m_rr + k) % N;
               if (!m_locked && in_valid[cand]) begin m_locked = 1; m_gnt = cand; end
            end
         end else if (xfer) begin
            exp_q.push_back({2'(m_gnt), in_last[m_gnt], in_data[m_gnt*DW +: DW]});
            m_ov = 1;
            if (in_last[m_gnt]) begin m_locked = 0; m_rr = (m_gnt + 1) % N; end
         end else if (out_ready) begin
            m_ov = 0;
         end
         if (!xfer && out_ready) m_ov = 0;
         step();
      end
      n_cmp++; if (exp_q.size() !== int'(out_valid) || dbg_rr !== 2'(m_rr)) begin
         n_err++; $display("FAIL rnd_end: pending=%0d ov=%b rr=%0d want pending=ov rr=%0d", exp_q.size(), out_valid, dbg_rr, m_rr); end
   endtask

   initial begin
      test_reset();
      test_three_beat();
      test_round_robin();
      test_stall_hold();
      test_backpressure();
      test_wrap();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ladybird_fifo_arbiter.md
LADYBIRD_FIFO_ARBITER -- requirements
Module: ladybird_fifo_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter DATA_W, default 8, payload width per beat.
REQ-003 Parameter SRC_W, default $clog2(N_REQ), width of the source index.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 anrst  input  1  reset, asynchronous, active-low.
REQ-006 nrst  input  1  synchronous reset, active-low, sampled on clk.
REQ-007 in_data  input  N_REQ*DATA_W  requester payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 in_valid  input  N_REQ  per-requester beat valid.
REQ-009 in_last  input  N_REQ  per-requester end-of-packet marker, qualified by in_valid.
REQ-010 in_ready  output  N_REQ  per-requester beat accept.
REQ-011 out_data  output  DATA_W  registered payload toward the FIFO write port.
REQ-012 out_valid  output  1  registered beat valid.
REQ-013 out_last  output  1  registered end-of-packet marker.
REQ-014 out_src  output  SRC_W  index of the requester that produced the current output beat.
REQ-015 out_ready  input  1  downstream accept (FIFO not full).
REQ-016 grant_active  output  1  high while in LOCKED state.

Function
REQ-017 The arbiter SHALL have two states: IDLE and LOCKED, plus registers gnt (SRC_W) and rr_ptr (SRC_W).
REQ-018 In IDLE, if any in_valid is high, the arbiter SHALL choose the first index i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ; at the next edge gnt<=i and state<=LOCKED.
REQ-019 In IDLE, in_ready SHALL be all zero; no beat transfers in IDLE.
REQ-020 In LOCKED, in_ready[gnt] SHALL equal (~out_valid | out_ready), combinationally; all other in_ready bits SHALL be 0.
REQ-021 Transfer: in_valid[gnt] & in_ready[gnt] at an edge SHALL load out_data<=in_data[gnt], out_last<=in_last[gnt], out_src<=gnt, out_valid<=1.
REQ-022 Without a transfer, out_ready=1 at an edge SHALL clear out_valid.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_last and out_src SHALL hold stable.
REQ-024 A transfer with in_last[gnt]=1 SHALL set state<=IDLE and rr_ptr<=(gnt+1) mod N_REQ; gnt=N_REQ-1 wraps rr_ptr to 0.
REQ-025 The grant SHALL be held across a packet until its last beat transfers, including cycles where in_valid[gnt]=0; there is no timeout.
REQ-026 Latency: in_valid rising in IDLE at cycle t -> grant_active at t+1 -> first beat on out_valid at t+2 (with out_ready=1).
REQ-027 Throughput in LOCKED with out_ready=1 SHALL be one beat per cycle; one IDLE cycle separates consecutive packets.
REQ-028 A single-beat packet (in_valid & in_last on first beat) SHALL return to IDLE after one transfer.
REQ-029 Requests arriving in LOCKED from non-granted requesters SHALL be ignored until the next IDLE evaluation.
REQ-030 No beat SHALL be duplicated or dropped: every accepted input beat appears exactly once on the output, in order per requester.

Reset
REQ-031 anrst low SHALL immediately force state=IDLE, gnt=0, rr_ptr=0, out_valid=0, out_data=0, out_last=0, out_src=0; in_ready=0 and grant_active=0 follow.
REQ-032 nrst low at an edge SHALL apply the same values synchronously, overriding any transfer that cycle.
REQ-033 Reset mid-packet SHALL abandon the packet; after release, arbitration restarts from rr_ptr=0.

Verification
REQ-034 N_REQ=4, DATA_W=8; reset, then in_valid=4'b0100, 3-beat packet 0x11,0x22,0x33, out_ready=1 -> out_valid at cycles t+2..t+4, out_src=2, out_last only on 0x33, rr_ptr=3 after.
REQ-035 All four requesters hold single-beat packets continuously from rr_ptr=0 -> grant order 0,1,2,3,0, out_src sequence identical, each beat followed by one IDLE cycle.
REQ-036 Granted requester 1 sends 0xA0, stalls in_valid 3 cycles, then sends 0xA1 with last, while requester 0 is valid throughout -> grant stays 1, output 0xA0,0xA1, then requester 0 granted.
REQ-037 out_ready=0 for 5 cycles with out_valid=1 holding 0x5C -> out_data stays 0x5C, in_ready[gnt]=0; after out_ready=1, next beat accepted same edge, none lost.
REQ-038 Grant requester 3, transfer last beat -> rr_ptr wraps to 0; with requesters 0 and 3 valid, requester 0 wins next.
REQ-039 Assert nrst low (then separately anrst low) mid-packet with out_valid=1 -> out_valid=0, state IDLE, rr_ptr=0; next arbitration picks lowest valid index.
